// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants and types for the instruction loader
//
// Purpose: state encoding, default ack/err bytes, header length and the
// word-address helper shared by instr_loader and byte_packer.
// Ports: none (package).

package loader_pkg;

  // Bytes per header and per data word; both are little-endian 32-bit values.
  localparam int HDR_BYTES = 4;

  localparam int         DEF_MAX_WORDS = 8192;
  localparam logic [7:0] DEF_ACK_BYTE  = 8'hAA;
  localparam logic [7:0] DEF_ERR_BYTE  = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ACK   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  // Byte address of word 'index' relative to 'base'; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] index);
    return base + (index << 2);
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - loader bus bundle: control, uart rx/tx, memory io port
//
// Purpose: groups every non-clock/reset signal of instr_loader.
// Ports (master = loader side):
//   start, rx_valid, rx_data, tx_ready   -> into the loader
//   tx_valid, tx_data                    -> ack byte to the uart transmitter
//   io_sel, we, en, addr_io, din         -> instruction memory io port
//   busy, done, err                      -> status

interface instr_loader_if;

  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        io_sel;
  logic        we;
  logic        en;
  logic [31:0] addr_io;
  logic [31:0] din;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  start,
    input  rx_valid,
    input  rx_data,
    input  tx_ready,
    output tx_valid,
    output tx_data,
    output io_sel,
    output we,
    output en,
    output addr_io,
    output din,
    output busy,
    output done,
    output err
  );

  modport slave (
    output start,
    output rx_valid,
    output rx_data,
    output tx_ready,
    input  tx_valid,
    input  tx_data,
    input  io_sel,
    input  we,
    input  en,
    input  addr_io,
    input  din,
    input  busy,
    input  done,
    input  err
  );

endinterface

// File: rtl/instr_loader_byte_packer.sv
// rtl/instr_loader_byte_packer.sv - little-endian byte-to-word packer
//
// Purpose: collects HDR_BYTES bytes into a 32-bit word, first byte in [7:0].
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clear        drop any partial word
//   in_valid     byte strobe
//   in_data      byte
//   word         assembled word, valid while word_valid is high
//   word_valid   combinational pulse in the cycle the last byte arrives

module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q;
  logic [31:0] sr_q;

  // Bytes enter at the top and shift down, so after four bytes the first
  // one sits in [7:0]. No clear is needed between words: four shifts
  // overwrite the whole register.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= 2'd0;
      sr_q  <= 32'd0;
    end else if (in_valid) begin
      cnt_q <= cnt_q + 2'd1;
      sr_q  <= {in_data, sr_q[31:8]};
    end
  end

  // The word is presented combinationally with the last byte so the
  // consumer can register it on the same edge that samples that byte.
  assign word       = {in_data, sr_q[31:8]};
  assign word_valid = in_valid && (cnt_q == 2'(HDR_BYTES - 1));

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - boot-time uart-to-instruction-memory program loader
//
// Purpose: after start, reads a 4-byte little-endian word count N, then N
// little-endian data words, writing each to BASE_ADDR + 4*index through the
// memory io port. Finishes by sending ACK_BYTE (or ERR_BYTE for N above
// MAX_WORDS) and then holds done (or err) until the next start or rst.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   instr_loader_if.master (start, rx_*, tx_*, io_sel, we, en,
//         addr_io, din, busy, done, err)

module instr_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = DEF_MAX_WORDS,
  parameter logic [7:0]  ACK_BYTE  = DEF_ACK_BYTE,
  parameter logic [7:0]  ERR_BYTE  = DEF_ERR_BYTE
) (
  input logic            clk,
  input logic            rst,
  instr_loader_if.master bus
);

  // One extra bit so an index equal to MAX_WORDS is representable.
  localparam int IDXW = $clog2(MAX_WORDS) + 1;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [IDXW-1:0]   n_q, n_d;
  logic [31:0]       din_q, din_d;
  logic [7:0]        tx_q, tx_d;
  logic              rej_q, rej_d;

  logic              pk_clear;
  logic              capture;
  logic              word_valid;
  logic [31:0]       word;
  logic              we_i;

  // Bytes are accepted only while a load is active; the WRITE cycle is
  // included so a byte arriving there starts the next word without a stall.
  assign capture = bus.rx_valid &&
                   (state_q inside {ST_HDR, ST_DATA, ST_WRITE});

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .in_valid   (capture),
    .in_data    (bus.rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      din_q   <= 32'd0;
      tx_q    <= 8'd0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      din_q   <= din_d;
      tx_q    <= tx_d;
      rej_q   <= rej_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    n_d      = n_q;
    din_d    = din_q;
    tx_d     = tx_q;
    rej_d    = rej_q;
    pk_clear = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.start) begin
          state_d  = ST_HDR;
          idx_d    = '0;
          n_d      = '0;
          rej_d    = 1'b0;
          pk_clear = 1'b1;
        end
      end

      ST_HDR: begin
        if (word_valid) begin
          if (word == 32'd0) begin
            state_d = ST_ACK;
            tx_d    = ACK_BYTE;
          end else if (word > 32'(MAX_WORDS)) begin
            state_d = ST_ACK;
            tx_d    = ERR_BYTE;
            rej_d   = 1'b1;
          end else begin
            state_d = ST_DATA;
            // Fits: N <= MAX_WORDS here.
            n_d     = word[IDXW-1:0];
          end
        end
      end

      ST_DATA: begin
        if (word_valid) begin
          din_d   = word;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        idx_d = idx_q + IDXW'(1);
        if (idx_d == n_q) begin
          state_d = ST_ACK;
          tx_d    = ACK_BYTE;
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_ACK: begin
        if (bus.tx_ready) begin
          state_d = rej_q ? ST_ERR : ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // All outputs decode from registered state so a reset edge clears them
  // in the very next cycle, including any write strobe.
  assign we_i         = (state_q == ST_WRITE);
  assign bus.we       = we_i;
  assign bus.en       = we_i;
  assign bus.addr_io  = we_i ? word_addr(BASE_ADDR, 32'(idx_q)) : 32'd0;
  assign bus.din      = we_i ? din_q : 32'd0;
  assign bus.io_sel   = state_q inside {ST_HDR, ST_DATA, ST_WRITE, ST_ACK};
  assign bus.busy     = state_q inside {ST_HDR, ST_DATA, ST_WRITE, ST_ACK};
  assign bus.tx_valid = (state_q == ST_ACK);
  assign bus.tx_data  = (state_q == ST_ACK) ? tx_q : 8'd0;
  assign bus.done     = (state_q == ST_DONE);
  assign bus.err      = (state_q == ST_ERR);

endmodule
